// File: rtl/csr_sequencer.sv
// rtl/csr_sequencer.sv - arbitrates CSR-file access between CSR instructions and trap/MRET sequences
module csr_sequencer #(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ins_req_i,
  input  logic                      ins_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] ins_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] ins_wdata_i,
  output logic                      ins_ack_o,
  output logic                      ins_err_o,
  output logic [CSR_DATA_WIDTH-1:0] ins_rdata_o,
  input  logic                      trap_req_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_epc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_tval_i,
  input  logic                      mret_req_i,
  output logic                      seq_done_o,
  output logic [CSR_DATA_WIDTH-1:0] seq_pc_o,
  output logic                      busy_o,
  output logic                      csr_en_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  input  logic                      csr_busy_i,
  input  logic                      csr_exists_i,
  input  logic                      csr_ro_i
);
  localparam logic [CSR_ADDR_WIDTH-1:0] MSR_MSTATUS = CSR_ADDR_WIDTH'('h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] MSR_MTVEC   = CSR_ADDR_WIDTH'('h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] MSR_MEPC    = CSR_ADDR_WIDTH'('h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] MSR_MCAUSE  = CSR_ADDR_WIDTH'('h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] MSR_MTVAL   = CSR_ADDR_WIDTH'('h343);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {F_INS, F_TRAP, F_MRET} flow_t;

  state_t                    state_q, state_d;
  flow_t                     flow_q, flow_d;
  logic [2:0]                step_q, step_d;
  logic                      seen_busy_q, seen_busy_d;
  logic                      en_q, en_d, we_q, we_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CSR_DATA_WIDTH-1:0] data_q, data_d;
  logic [CSR_DATA_WIDTH-1:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
  logic                      ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d, pc_q, pc_d;
  logic                      complete;

  function automatic logic [CSR_DATA_WIDTH-1:0] trap_mstatus(input logic [CSR_DATA_WIDTH-1:0] s);
    logic [CSR_DATA_WIDTH-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [CSR_DATA_WIDTH-1:0] mret_mstatus(input logic [CSR_DATA_WIDTH-1:0] s);
    logic [CSR_DATA_WIDTH-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode offsets only interrupts (cause MSB set); exceptions go to the base.
  function automatic logic [CSR_DATA_WIDTH-1:0] handler_pc(input logic [CSR_DATA_WIDTH-1:0] mtvec,
                                                          input logic [CSR_DATA_WIDTH-1:0] cause);
    logic [CSR_DATA_WIDTH-1:0] pc;
    pc = {mtvec[CSR_DATA_WIDTH-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && cause[CSR_DATA_WIDTH-1])
      pc = pc + {cause[CSR_DATA_WIDTH-3:0], 2'b00};
    return pc;
  endfunction

  assign complete = (state_q == S_ACCESS) && seen_busy_q && !csr_busy_i;

  always_comb begin
    state_d     = state_q;
    flow_d      = flow_q;
    step_d      = step_q;
    seen_busy_d = seen_busy_q | csr_busy_i;
    en_d        = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    pc_d        = pc_q;
    case (state_q)
      S_IDLE: begin
        seen_busy_d = 1'b0;
        step_d      = 3'd0;
        if (trap_req_i || mret_req_i) begin
          flow_d  = trap_req_i ? F_TRAP : F_MRET;
          cause_d = trap_cause_i;
          epc_d   = trap_epc_i;
          tval_d  = trap_tval_i;
          state_d = S_ACCESS;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = MSR_MSTATUS;
          data_d  = '0;
        end else if (ins_req_i) begin
          if (!csr_exists_i || (ins_we_i && csr_ro_i)) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            flow_d  = F_INS;
            state_d = S_ACCESS;
            en_d    = 1'b1;
            we_d    = ins_we_i;
            addr_d  = ins_addr_i;
            data_d  = ins_wdata_i;
          end
        end
      end
      S_ACCESS: begin
        if (complete) begin
          seen_busy_d = 1'b0;
          en_d        = 1'b1;
          we_d        = 1'b1;
          step_d      = step_q + 3'd1;
          case (flow_q)
            F_TRAP: begin
              case (step_q)
                3'd0: begin addr_d = MSR_MSTATUS; data_d = trap_mstatus(csr_data_i); end
                3'd1: begin addr_d = MSR_MEPC;    data_d = epc_q;   end
                3'd2: begin addr_d = MSR_MCAUSE;  data_d = cause_q; end
                3'd3: begin addr_d = MSR_MTVAL;   data_d = tval_q;  end
                3'd4: begin addr_d = MSR_MTVEC;   we_d   = 1'b0;    end
                default: begin
                  en_d    = 1'b0;
                  we_d    = 1'b0;
                  done_d  = 1'b1;
                  pc_d    = handler_pc(csr_data_i, cause_q);
                  state_d = S_RESP;
                end
              endcase
            end
            F_MRET: begin
              case (step_q)
                3'd0: begin addr_d = MSR_MSTATUS; data_d = mret_mstatus(csr_data_i); end
                3'd1: begin addr_d = MSR_MEPC;    we_d   = 1'b0; end
                default: begin
                  en_d    = 1'b0;
                  we_d    = 1'b0;
                  done_d  = 1'b1;
                  pc_d    = csr_data_i;
                  state_d = S_RESP;
                end
              endcase
            end
            default: begin
              en_d    = 1'b0;
              we_d    = 1'b0;
              ack_d   = 1'b1;
              rdata_d = csr_data_i;
              state_d = S_RESP;
            end
          endcase
        end
      end
      // One cycle here lets the requester drop its level request before re-arbitration.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      flow_q      <= F_INS;
      step_q      <= 3'd0;
      seen_busy_q <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      tval_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      step_q      <= step_d;
      seen_busy_q <= seen_busy_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      tval_q      <= tval_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      pc_q        <= pc_d;
    end
  end

  assign ins_ack_o   = ack_q;
  assign ins_err_o   = err_q;
  assign ins_rdata_o = rdata_q;
  assign seq_done_o  = done_q;
  assign seq_pc_o    = pc_q;
  assign busy_o      = (state_q != S_IDLE);
  assign csr_en_o    = en_q;
  assign csr_we_o    = we_q;
  // While idle the address follows the pending instruction so exists/ro can qualify it.
  assign csr_addr_o  = (state_q == S_IDLE) ? ins_addr_i : addr_q;
  assign csr_data_o  = data_q;

endmodule

// File: tb/tb_csr_sequencer.sv
// tb/tb_csr_sequencer.sv - scoreboard bench for csr_sequencer against a behavioural CSR model
module tb_csr_sequencer;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MVENDORID = 12'hF11, A_NONE = 12'h7C0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_req = 1'b0, ins_we = 1'b0;
  logic [11:0] ins_addr = '0;
  logic [31:0] ins_wdata = '0;
  logic        ins_ack, ins_err;
  logic [31:0] ins_rdata;
  logic        trap_req = 1'b0, mret_req = 1'b0;
  logic [31:0] trap_cause = '0, trap_epc = '0, trap_tval = '0;
  logic        seq_done, busy;
  logic [31:0] seq_pc;
  logic        csr_en, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        csr_busy = 1'b0;
  logic        csr_exists, csr_ro;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csr_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .ins_req_i(ins_req), .ins_we_i(ins_we), .ins_addr_i(ins_addr), .ins_wdata_i(ins_wdata),
    .ins_ack_o(ins_ack), .ins_err_o(ins_err), .ins_rdata_o(ins_rdata),
    .trap_req_i(trap_req), .trap_cause_i(trap_cause), .trap_epc_i(trap_epc), .trap_tval_i(trap_tval),
    .mret_req_i(mret_req), .seq_done_o(seq_done), .seq_pc_o(seq_pc), .busy_o(busy),
    .csr_en_o(csr_en), .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_data_o(csr_wdata),
    .csr_data_i(csr_rdata), .csr_busy_i(csr_busy), .csr_exists_i(csr_exists), .csr_ro_i(csr_ro)
  );

  function automatic bit f_exists(input logic [11:0] a);
    return a inside {A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MVENDORID};
  endfunction
  function automatic bit f_ro(input logic [11:0] a);
    return a[11:10] == 2'b11;
  endfunction

  // CSR file: busy for one cycle after each strobe, old value returned, write applied on strobe.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  assign csr_exists = f_exists(csr_addr);
  assign csr_ro     = f_ro(csr_addr);
  always @(posedge clk) begin
    csr_busy <= csr_en;
    if (csr_en) begin
      csr_rdata <= mem[csr_addr];
      if (csr_we) mem[csr_addr] <= csr_wdata;
    end
  end

  typedef struct {
    bit          is_seq;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
    int          nacc;
  } exp_t;
  exp_t sb[$];
  logic [31:0] model_csr [0:4095] = '{default: 32'h0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per ack/done and counts CSR strobes since the last response.
  int   en_count = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) en_count = 0;
      else begin
        if (csr_en) en_count++;
        if (ins_ack || seq_done) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_response: ack=%0b done=%0b with empty scoreboard", ins_ack, seq_done);
          end else begin
            mon_e = sb.pop_front();
            chk("resp_kind", {31'd0, seq_done}, {31'd0, mon_e.is_seq});
            chk("resp_cycle", cyc, mon_e.cyc);
            chk("csr_accesses", en_count, mon_e.nacc);
            if (mon_e.is_seq) chk("seq_pc", seq_pc, mon_e.data);
            else begin
              chk("ins_err", {31'd0, ins_err}, {31'd0, mon_e.err});
              if (mon_e.chk_data) chk("ins_rdata", ins_rdata, mon_e.data);
            end
          end
          en_count = 0;
        end
      end
    end
  end

  function automatic logic [31:0] ms_after_trap(input logic [31:0] s);
    return (s & ~32'h1888) | 32'h1800 | ((s & 32'h8) << 4);
  endfunction
  function automatic logic [31:0] ms_after_mret(input logic [31:0] s);
    return (s & ~32'h1888) | 32'h1880 | ((s >> 4) & 32'h8);
  endfunction

  task automatic push_ins(input bit we, input logic [11:0] a, input logic [31:0] d, input int r);
    exp_t e;
    e.is_seq = 1'b0;
    if (!f_exists(a) || (we && f_ro(a))) begin
      e.err = 1'b1; e.chk_data = 1'b0; e.data = '0; e.cyc = r + 1; e.nacc = 0;
    end else begin
      e.err = 1'b0; e.chk_data = 1'b1; e.data = model_csr[a]; e.cyc = r + 4; e.nacc = 1;
      if (we) model_csr[a] = d;
    end
    sb.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval, input int r);
    exp_t        e;
    logic [31:0] tv;
    model_csr[A_MSTATUS] = ms_after_trap(model_csr[A_MSTATUS]);
    model_csr[A_MEPC]    = epc;
    model_csr[A_MCAUSE]  = cause;
    model_csr[A_MTVAL]   = tval;
    tv     = model_csr[A_MTVEC];
    e.data = tv & ~32'h3;
    if ((tv & 32'h3) == 32'h1 && cause[31]) e.data = e.data + (cause & 32'h3FFF_FFFF) * 4;
    e.is_seq = 1'b1; e.err = 1'b0; e.chk_data = 1'b1; e.cyc = r + 19; e.nacc = 6;
    sb.push_back(e);
  endtask

  task automatic push_mret(input int r);
    exp_t e;
    model_csr[A_MSTATUS] = ms_after_mret(model_csr[A_MSTATUS]);
    e.is_seq = 1'b1; e.err = 1'b0; e.chk_data = 1'b1; e.data = model_csr[A_MEPC];
    e.cyc = r + 10; e.nacc = 3;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin tests++; fails++; $display("FAIL idle_timeout: busy_o=%0b after %0d cycles", busy, n); end
  endtask

  task automatic wait_resp(input bit seq);
    int n = 0;
    while (!(seq ? seq_done : ins_ack) && n < 60) begin @(negedge clk); n++; end
    if (!(seq ? seq_done : ins_ack)) begin
      tests++; fails++;
      $display("FAIL resp_timeout: no %s after %0d cycles", seq ? "seq_done_o" : "ins_ack_o", n);
    end
  endtask

  task automatic do_ins(input bit we, input logic [11:0] a, input logic [31:0] d);
    wait_idle();
    ins_req = 1'b1; ins_we = we; ins_addr = a; ins_wdata = d;
    push_ins(we, a, d, cyc);
    wait_resp(1'b0);
    ins_req = 1'b0; ins_we = 1'b0; ins_addr = '0; ins_wdata = '0;
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval);
    wait_idle();
    trap_req = 1'b1; trap_cause = cause; trap_epc = epc; trap_tval = tval;
    push_trap(cause, epc, tval, cyc);
    @(negedge clk);
    trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
    wait_resp(1'b1);
    trap_req = 1'b0;
  endtask

  task automatic do_mret();
    wait_idle();
    mret_req = 1'b1;
    push_mret(cyc);
    wait_resp(1'b1);
    mret_req = 1'b0;
  endtask

  logic [11:0] addr_tab [8];

  initial begin
    int r;
    int n;
    addr_tab[0] = A_MSTATUS; addr_tab[1] = A_MTVEC;     addr_tab[2] = A_MSCRATCH; addr_tab[3] = A_MEPC;
    addr_tab[4] = A_MCAUSE;  addr_tab[5] = A_MTVAL;     addr_tab[6] = A_MVENDORID; addr_tab[7] = A_NONE;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_en", {31'd0, csr_en}, 32'd0);
    chk("reset_ack", {31'd0, ins_ack}, 32'd0);
    chk("reset_done", {31'd0, seq_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_ins(1'b1, A_MSCRATCH, 32'hDEADBEEF);
    do_ins(1'b0, A_MSCRATCH, 32'h0);
    do_ins(1'b1, A_MVENDORID, 32'h1234_5678);
    do_ins(1'b0, A_MVENDORID, 32'h0);
    do_ins(1'b0, A_NONE, 32'h0);

    do_ins(1'b1, A_MSTATUS, 32'h8);
    do_ins(1'b1, A_MTVEC, 32'h100);
    do_trap(32'd2, 32'h40, 32'h1234);
    do_ins(1'b0, A_MSTATUS, 32'h0);
    do_ins(1'b0, A_MEPC, 32'h0);
    do_ins(1'b0, A_MCAUSE, 32'h0);
    do_ins(1'b0, A_MTVAL, 32'h0);

    do_ins(1'b1, A_MTVEC, 32'h201);
    do_trap(32'h8000_0007, 32'h88, 32'h0);

    wait_idle();
    trap_req = 1'b1; trap_cause = 32'h8000_0003; trap_epc = 32'h120; trap_tval = 32'h5;
    ins_req = 1'b1; ins_we = 1'b0; ins_addr = A_MSTATUS;
    r = cyc;
    push_trap(32'h8000_0003, 32'h120, 32'h5, r);
    push_ins(1'b0, A_MSTATUS, 32'h0, r + 20);
    wait_resp(1'b1);
    trap_req = 1'b0;
    wait_resp(1'b0);
    ins_req = 1'b0; ins_addr = '0;

    do_ins(1'b1, A_MSTATUS, 32'h1880);
    do_ins(1'b1, A_MEPC, 32'h44);
    do_mret();
    do_ins(1'b0, A_MSTATUS, 32'h0);

    do_ins(1'b1, A_MSTATUS, 32'h8);
    wait_idle();
    trap_req = 1'b1; trap_cause = 32'd5; trap_epc = 32'h300; trap_tval = 32'h77;
    r = cyc;
    repeat (7) @(negedge clk);
    chk("pre_reset_en", {31'd0, csr_en}, 32'd1);
    chk("pre_reset_addr", {20'd0, csr_addr}, {20'd0, A_MEPC});
    #2;
    rst = 1'b1; trap_req = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {31'd0, csr_en}, 32'd0);
    chk("rst_we", {31'd0, csr_we}, 32'd0);
    chk("rst_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_ack", {31'd0, ins_ack}, 32'd0);
    chk("rst_err", {31'd0, ins_err}, 32'd0);
    chk("rst_rdata", ins_rdata, 32'd0);
    chk("rst_done", {31'd0, seq_done}, 32'd0);
    chk("rst_pc", seq_pc, 32'd0);
    model_csr[A_MSTATUS] = ms_after_trap(model_csr[A_MSTATUS]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_ins(1'b0, A_MSTATUS, 32'h0);
    do_ins(1'b0, A_MEPC, 32'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1: do_ins(1'b0, addr_tab[$urandom_range(0, 7)], 32'h0);
        2:    do_ins(1'b1, addr_tab[$urandom_range(0, 7)], $urandom);
        3:    do_trap({$urandom_range(0, 1) == 1, 31'($urandom_range(0, 15))}, $urandom, $urandom);
        4:    do_mret();
        default: do_ins(1'b1, A_MSTATUS, $urandom);
      endcase
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_empty", sb.size(), 32'd0);
    for (int i = 0; i < 6; i++) chk("csr_file_contents", mem[addr_tab[i]], model_csr[addr_tab[i]]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
